branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
- Sequences pipeline control-flow redirection from the branch condition unit's verdict in EX.
- Decides whether each resolved B- or J-type instruction redirects fetch, and holds the redirect across memory/cache stalls.
- Drives IF/ID and ID/EX flushes, then squashes wrong-path resolves for a fixed window.
- Keeps saturating resolve/taken counters for per-core performance monitoring.

Parameters:
- SQUASH_CYCLES, 2: non-stalled cycles after a consumed redirect during which EX resolves are ignored (0..15).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  pipeline stall (cache miss / memory busy); no pipeline advance this cycle.
- ex_valid  input  1  EX stage holds a valid instruction.
- ex_opcode  input  7  EX opcode.
- ex_br_type  input  3  branch funct3 from EX.
- br_taken  input  1  branch condition unit verdict for the EX instruction, valid same cycle.
- ex_target  input  32  computed branch/jump target.
- cnt_clr  input  1  synchronous clear of both counters.
- pc_redirect  output  1  fetch must load pc_target.
- pc_target  output  32  redirect address.
- flush_if_id  output  1  flush the IF/ID register.
- flush_id_ex  output  1  flush the ID/EX register.
- err_illegal_br  output  1  sticky: B-type with br_type 2 or 3 seen.
- cnt_resolved  output  CNT_W  resolved control-flow instructions.
- cnt_taken  output  CNT_W  taken redirects.

Behaviour:
- Opcodes: B = 7'b1100011, J = 7'b1101111.
- resolve = ex_valid & !stall & opcode in {B,J} & state==IDLE. Other opcodes are ignored.
- taken = resolve & (J | (B & br_taken & br_type in {0,1,4,5,6,7})).
- B with br_type 2 or 3:
  - Treated as not taken, but still counted as resolved.
  - Sets err_illegal_br, which clears only on reset.
- States: IDLE, REDIRECT, SQUASH.
- IDLE:
  - On taken: latch ex_target into pc_target; next state REDIRECT.
  - Otherwise stay in IDLE.
- REDIRECT:
  - pc_redirect, flush_if_id and flush_id_ex = 1 (registered; first asserted the cycle after resolve).
  - Hold all three and pc_target stable while stall=1.
  - Redirect is consumed in the first REDIRECT cycle with stall=0.
  - On consume: next state SQUASH with counter loaded to SQUASH_CYCLES; if SQUASH_CYCLES==0, go straight to IDLE.
- SQUASH:
  - Counter decrements only on stall=0 cycles.
  - Go to IDLE when a non-stalled cycle sees counter==1.
  - EX activity is ignored: no counting, no error set.
- REDIRECT and SQUASH both ignore EX resolves (wrong-path instructions).
- Counters:
  - cnt_resolved += 1 on resolve; cnt_taken += 1 on taken.
  - Both saturate at all ones; no wrap.
  - cnt_clr has priority over an increment in the same cycle (result 0).
- Outputs are registered. pc_target holds its last value when pc_redirect=0.
- Reset value of every output is 0: pc_redirect, pc_target, both flushes, err_illegal_br, both counters.
- Reset asserted mid-REDIRECT or mid-SQUASH: immediate return to IDLE, all outputs 0; the pending redirect is dropped.
- stall=1 in the resolve cycle means no resolve. The EX instruction is re-presented and evaluated when stall drops.

Test Plan:
- Taken path: B beq, br_taken=1, target 0x100, stall=0 -> next cycle pc_redirect=1, pc_target=0x100, both flushes=1 for exactly 1 cycle; cnt_resolved=1, cnt_taken=1.
- Stall hold: J to 0x200, stall=1 for 3 cycles after the resolve cycle -> pc_redirect held 4 cycles with pc_target=0x200 stable; SQUASH begins after stall drops.
- Squash window: SQUASH_CYCLES=2; a taken B is presented in both squash cycles -> no redirect, counters unchanged; a taken B in the third cycle redirects.
- Not-taken and illegal: B br_taken=0 -> no redirect, cnt_resolved+1 only. B br_type=3 with br_taken=1 -> no redirect, err_illegal_br=1 and sticky.
- Saturation and clear: CNT_W=4, 17 taken jumps -> cnt_taken=15. cnt_clr concurrent with a resolve -> both counters 0.
- Async reset: reset low during REDIRECT -> all outputs 0 without a clock edge. After release, a new taken B redirects normally.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller.
// Turns the EX-stage branch verdict into a registered fetch redirect plus
// IF/ID and ID/EX flushes, holds the redirect across stalls, then ignores
// wrong-path EX resolves for a short squash window.
// Also keeps saturating resolve/taken counters for performance monitoring.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | accepting EX resolves; a taken one arms a redirect
// REDIRECT | pc_redirect and both flushes asserted; held while stalled
// SQUASH   | EX resolves ignored for SQUASH_CYCLES non-stalled cycles
module branch_redirect_ctrl #(
  parameter int SQUASH_CYCLES = 2,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic [6:0]       ex_opcode,
  input  logic [2:0]       ex_br_type,
  input  logic             br_taken,
  input  logic [31:0]      ex_target,
  input  logic             cnt_clr,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             err_illegal_br,
  output logic [CNT_W-1:0] cnt_resolved,
  output logic [CNT_W-1:0] cnt_taken
);

  localparam logic [6:0]       OPC_B   = 7'b1100011;
  localparam logic [6:0]       OPC_J   = 7'b1101111;
  localparam logic [3:0]       SQ_LOAD = 4'(SQUASH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    SQUASH   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] sq_cnt_q, sq_cnt_d;

  logic is_b;
  logic is_j;
  logic br_type_bad;
  logic resolve;
  logic taken;
  logic illegal;

  // Resolve qualification: only a non-stalled, valid B/J in IDLE counts.
  always_comb begin
    is_b        = (ex_opcode == OPC_B);
    is_j        = (ex_opcode == OPC_J);
    br_type_bad = (ex_br_type == 3'd2) || (ex_br_type == 3'd3);
    resolve     = ex_valid && !stall && (is_b || is_j) && (state_q == IDLE);
    taken       = resolve && (is_j || (is_b && br_taken && !br_type_bad));
    illegal     = resolve && is_b && br_type_bad;
  end

  // Next-state and squash-window counter.
  always_comb begin
    state_d  = state_q;
    sq_cnt_d = sq_cnt_q;
    case (state_q)
      IDLE: begin
        if (taken) state_d = REDIRECT;
      end
      REDIRECT: begin
        // First non-stalled cycle in REDIRECT consumes the redirect.
        if (!stall) begin
          if (SQ_LOAD == 4'd0) begin
            state_d = IDLE;
          end else begin
            state_d  = SQUASH;
            sq_cnt_d = SQ_LOAD;
          end
        end
      end
      SQUASH: begin
        if (!stall) begin
          if (sq_cnt_q <= 4'd1) begin
            state_d  = IDLE;
            sq_cnt_d = 4'd0;
          end else begin
            sq_cnt_d = sq_cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        sq_cnt_d = 4'd0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sq_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      sq_cnt_q <= sq_cnt_d;
    end
  end

  // Registered redirect/flush outputs track REDIRECT; target latched on taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_redirect <= 1'b0;
      flush_if_id <= 1'b0;
      flush_id_ex <= 1'b0;
      pc_target   <= 32'd0;
    end else begin
      pc_redirect <= (state_d == REDIRECT);
      flush_if_id <= (state_d == REDIRECT);
      flush_id_ex <= (state_d == REDIRECT);
      if (taken) pc_target <= ex_target;
    end
  end

  // Sticky illegal branch-type flag; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_illegal_br <= 1'b0;
    end else if (illegal) begin
      err_illegal_br <= 1'b1;
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_resolved <= '0;
      cnt_taken    <= '0;
    end else if (cnt_clr) begin
      cnt_resolved <= '0;
      cnt_taken    <= '0;
    end else begin
      if (resolve && (cnt_resolved != CNT_MAX)) cnt_resolved <= cnt_resolved + CNT_ONE;
      if (taken && (cnt_taken != CNT_MAX))      cnt_taken    <= cnt_taken + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl (SQUASH_CYCLES=2, CNT_W=4).
module tb_branch_redirect_ctrl;

  localparam logic [6:0] OB = 7'b1100011;
  localparam logic [6:0] OJ = 7'b1101111;
  localparam logic [6:0] OR = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, ex_valid, br_taken, cnt_clr;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_br_type;
  logic [31:0] ex_target;
  logic        pc_redirect, flush_if_id, flush_id_ex, err_illegal_br;
  logic [31:0] pc_target;
  logic [3:0]  cnt_resolved, cnt_taken;

  int tests = 0;
  int fails = 0;

  branch_redirect_ctrl #(.SQUASH_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .ex_valid(ex_valid),
    .ex_opcode(ex_opcode), .ex_br_type(ex_br_type), .br_taken(br_taken),
    .ex_target(ex_target), .cnt_clr(cnt_clr), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .err_illegal_br(err_illegal_br), .cnt_resolved(cnt_resolved), .cnt_taken(cnt_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        valid;
    logic [6:0]  opc;
    logic [2:0]  bt;
    logic        tk;
    logic [31:0] tgt;
    logic        clr;
    logic        e_redir;
    logic [31:0] e_tgt;
    logic        e_err;
    logic [3:0]  e_res;
    logic [3:0]  e_tk;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic s, logic v, logic [6:0] o, logic [2:0] b, logic t,
                              logic [31:0] g, logic c, logic er, logic [31:0] et,
                              logic ee, logic [3:0] eres, logic [3:0] etk);
    vec_t r;
    r.stall = s; r.valid = v; r.opc = o; r.bt = b; r.tk = t; r.tgt = g; r.clr = c;
    r.e_redir = er; r.e_tgt = et; r.e_err = ee; r.e_res = eres; r.e_tk = etk;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic s, logic v, logic [6:0] o, logic [2:0] b, logic t,
                       logic [31:0] g, logic c);
    stall = s; ex_valid = v; ex_opcode = o; ex_br_type = b; br_taken = t;
    ex_target = g; cnt_clr = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string tag, logic er, logic [31:0] et, logic ee,
                           logic [3:0] eres, logic [3:0] etk);
    check({tag, ".redirect"}, {31'd0, pc_redirect}, {31'd0, er});
    check({tag, ".flush_if_id"}, {31'd0, flush_if_id}, {31'd0, er});
    check({tag, ".flush_id_ex"}, {31'd0, flush_id_ex}, {31'd0, er});
    check({tag, ".target"}, pc_target, et);
    check({tag, ".err"}, {31'd0, err_illegal_br}, {31'd0, ee});
    check({tag, ".cnt_res"}, {28'd0, cnt_resolved}, {28'd0, eres});
    check({tag, ".cnt_tk"}, {28'd0, cnt_taken}, {28'd0, etk});
  endtask

  initial begin
    // stall valid opc bt tk tgt clr | redir tgt err res tk
    vecs[0]  = mk(0, 0, OB, 0, 0, 32'h000, 0, 0, 32'h000, 0, 0, 0);
    vecs[1]  = mk(0, 1, OB, 0, 1, 32'h100, 0, 1, 32'h100, 0, 1, 1); // beq taken
    vecs[2]  = mk(0, 1, OB, 0, 1, 32'h300, 0, 0, 32'h100, 0, 1, 1); // consume, wrong path
    vecs[3]  = mk(0, 1, OB, 0, 1, 32'h400, 0, 0, 32'h100, 0, 1, 1); // squash 1
    vecs[4]  = mk(0, 1, OB, 1, 1, 32'h440, 0, 0, 32'h100, 0, 1, 1); // squash 2
    vecs[5]  = mk(0, 1, OB, 1, 1, 32'h500, 0, 1, 32'h500, 0, 2, 2); // third cycle redirects
    vecs[6]  = mk(1, 1, OJ, 0, 0, 32'h600, 0, 1, 32'h500, 0, 2, 2); // held by stall
    vecs[7]  = mk(0, 0, OJ, 0, 0, 32'h600, 0, 0, 32'h500, 0, 2, 2); // consume
    vecs[8]  = mk(1, 1, OB, 3, 1, 32'h000, 0, 0, 32'h500, 0, 2, 2); // squash stalled
    vecs[9]  = mk(0, 1, OB, 3, 1, 32'h000, 0, 0, 32'h500, 0, 2, 2); // squash, no err
    vecs[10] = mk(0, 0, OB, 0, 0, 32'h000, 0, 0, 32'h500, 0, 2, 2); // squash end
    vecs[11] = mk(0, 1, OB, 0, 0, 32'h650, 0, 0, 32'h500, 0, 3, 2); // not taken
    vecs[12] = mk(0, 1, OB, 3, 1, 32'h700, 0, 0, 32'h500, 1, 4, 2); // illegal type
    vecs[13] = mk(0, 1, OR, 0, 1, 32'h740, 0, 0, 32'h500, 1, 4, 2); // other opcode
    vecs[14] = mk(1, 1, OJ, 0, 0, 32'h800, 0, 0, 32'h500, 1, 4, 2); // stalled resolve
    vecs[15] = mk(0, 1, OJ, 0, 0, 32'h800, 0, 1, 32'h800, 1, 5, 3); // re-presented J
    vecs[16] = mk(0, 0, OB, 0, 0, 32'h000, 0, 0, 32'h800, 1, 5, 3);
    vecs[17] = mk(0, 0, OB, 0, 0, 32'h000, 0, 0, 32'h800, 1, 5, 3);
    vecs[18] = mk(0, 1, OB, 2, 0, 32'h000, 0, 0, 32'h800, 1, 5, 3); // squash, type 2 ignored
    vecs[19] = mk(0, 1, OJ, 0, 0, 32'h900, 1, 1, 32'h900, 1, 0, 0); // clr beats increment

    reset = 1'b0;
    drive(0, 0, 7'd0, 3'd0, 0, 32'd0, 0);
    repeat (2) step();
    check_all("reset", 0, 32'h0, 0, 4'd0, 4'd0);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].stall, vecs[i].valid, vecs[i].opc, vecs[i].bt, vecs[i].tk,
            vecs[i].tgt, vecs[i].clr);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_redir, vecs[i].e_tgt, vecs[i].e_err,
                vecs[i].e_res, vecs[i].e_tk);
    end
    // finish the redirect armed by vec19 and its squash window
    drive(0, 0, OB, 0, 0, 32'd0, 0);
    repeat (3) step();

    // Stall hold: J to 0x200 with 3 stall cycles after resolve
    drive(0, 1, OJ, 0, 0, 32'h200, 1);  // clear counters together with this resolve
    step();
    check("hold.redir0", {31'd0, pc_redirect}, 32'd1);
    check("hold.tk_clr", {28'd0, cnt_taken}, 32'd0);
    drive(1, 1, OJ, 0, 0, 32'h2f0, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("hold.redir%0d", i), {31'd0, pc_redirect}, 32'd1);
      check($sformatf("hold.tgt%0d", i), pc_target, 32'h200);
    end
    drive(0, 1, OJ, 0, 0, 32'h2f0, 0);
    step();
    check("hold.consumed", {31'd0, pc_redirect}, 32'd0);
    step();  // squash 2
    step();  // back in IDLE, J presented throughout -> nothing
    check("hold.squashed", {28'd0, cnt_taken}, 32'd0);

    // Saturation: 17 taken jumps into a 4-bit counter
    drive(0, 0, OJ, 0, 0, 32'd0, 0);
    for (int i = 0; i < 17; i++) begin
      drive(0, 1, OJ, 0, 0, 32'h1000 + 32'(i), 0);
      step();
      check($sformatf("sat.tk%0d", i), {28'd0, cnt_taken}, (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      drive(0, 0, OJ, 0, 0, 32'd0, 0);
      repeat (3) step();
    end
    check("sat.res", {28'd0, cnt_resolved}, 32'd15);
    drive(0, 1, OB, 0, 1, 32'h1200, 1);
    step();
    check("clr.res", {28'd0, cnt_resolved}, 32'd0);
    check("clr.tk", {28'd0, cnt_taken}, 32'd0);
    check("clr.redir", {31'd0, pc_redirect}, 32'd1);
    drive(0, 0, OB, 0, 0, 32'd0, 0);
    repeat (3) step();

    // Illegal flag set, then async reset mid-REDIRECT
    drive(0, 1, OB, 3, 1, 32'h0, 0);
    step();
    check("ill.err", {31'd0, err_illegal_br}, 32'd1);
    drive(0, 1, OJ, 0, 0, 32'h3000, 0);
    step();
    check("ar.redir_pre", {31'd0, pc_redirect}, 32'd1);
    drive(1, 0, OB, 0, 0, 32'd0, 0);
    #2 reset = 1'b0;
    #1;
    check_all("ar", 0, 32'h0, 0, 4'd0, 4'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, OB, 0, 0, 32'd0, 0);
    step();
    check("ar.idle", {31'd0, pc_redirect}, 32'd0);
    drive(0, 1, OB, 4, 1, 32'h4000, 0);
    step();
    check_all("ar.after", 1, 32'h4000, 0, 4'd1, 4'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
